reg_file: RTL

- Architectural register file with rename-tag tracking; sits directly downstream of the reorder buffer's commit port and alongside its issue port.
- Holds the 32 x 32-bit architectural registers and, per register, a busy flag plus the ROB entry of the youngest in-flight writer.
- Serves the decoder's two source-operand lookups. For a renamed register it queries the ROB's ready1/value1 and ready2/value2 ports, so issue gets either a value or a tag.

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file.sv | 104 ++++++++++
 2 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and read-port result type for the architectural register file.
// ROB_BIT must track the reorder buffer's entry-index width.
package reg_file_pkg;

  localparam int ROB_BIT   = 4;
  localparam int REG_BIT   = 5;
  localparam int ROB_SIZE  = 1 << ROB_BIT;
  localparam int REG_COUNT = 32;

  typedef struct packed {
    logic               ready;
    logic [31:0]        value;
    logic [ROB_BIT-1:0] tag;
  } rd_port_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file with per-register busy flag and youngest-writer ROB tag.
// Source lookups are combinational and bypass same-cycle commits and finished ROB entries.
module reg_file #(
  parameter int ROB_BIT = reg_file_pkg::ROB_BIT,
  parameter int REG_BIT = reg_file_pkg::REG_BIT
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rdy_in,
  input  logic               clear_up,
  input  logic               issue_pollute,
  input  logic [REG_BIT-1:0] issue_reg_id,
  input  logic [ROB_BIT-1:0] issue_rob_entry,
  input  logic               rob_commit,
  input  logic [REG_BIT-1:0] commit_rd_reg_id,
  input  logic [ROB_BIT-1:0] commit_rob_entry,
  input  logic [31:0]        commit_value,
  input  logic [REG_BIT-1:0] rs1_id,
  input  logic [REG_BIT-1:0] rs2_id,
  output logic               rs1_ready,
  output logic               rs2_ready,
  output logic [31:0]        rs1_value,
  output logic [31:0]        rs2_value,
  output logic [ROB_BIT-1:0] rs1_rob_entry,
  output logic [ROB_BIT-1:0] rs2_rob_entry,
  output logic [ROB_BIT-1:0] get_rob_entry1,
  output logic [ROB_BIT-1:0] get_rob_entry2,
  input  logic               ready1,
  input  logic               ready2,
  input  logic [31:0]        value1,
  input  logic [31:0]        value2
);
  import reg_file_pkg::*;

  logic [31:0]          regs [REG_COUNT];
  logic [ROB_BIT-1:0]   tags [REG_COUNT];
  logic [REG_COUNT-1:0] busy;

  logic commit_fire;
  logic issue_fire;
  rd_port_t rd1, rd2;

  // x0 is filtered here, so it is never written and never marked busy.
  assign commit_fire = rdy_in && rob_commit && (commit_rd_reg_id != '0);
  assign issue_fire  = rdy_in && issue_pollute && (issue_reg_id != '0) && !clear_up;

  function automatic rd_port_t read_port(input logic [REG_BIT-1:0] id,
                                         input logic               rob_ready,
                                         input logic [31:0]        rob_value);
    rd_port_t r;
    r.tag   = tags[id];
    r.ready = 1'b1;
    r.value = regs[id];
    if (busy[id]) begin
      if (commit_fire && (commit_rd_reg_id == id) && (commit_rob_entry == tags[id]))
        r.value = commit_value;
      else if (rob_ready)
        r.value = rob_value;
      else begin
        r.ready = 1'b0;
        r.value = '0;
      end
    end
    return r;
  endfunction

  always_comb begin
    rd1 = read_port(rs1_id, ready1, value1);
    rd2 = read_port(rs2_id, ready2, value2);
  end

  assign get_rob_entry1 = tags[rs1_id];
  assign get_rob_entry2 = tags[rs2_id];
  assign rs1_ready      = rd1.ready;
  assign rs1_value      = rd1.value;
  assign rs1_rob_entry  = rd1.tag;
  assign rs2_ready      = rd2.ready;
  assign rs2_value      = rd2.value;
  assign rs2_rob_entry  = rd2.tag;

  // Later assignments win: a flush or a same-cycle re-issue overrides the commit's busy clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy <= '0;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
      end
    end else if (rdy_in) begin
      if (commit_fire) begin
        regs[commit_rd_reg_id] <= commit_value;
        if (tags[commit_rd_reg_id] == commit_rob_entry)
          busy[commit_rd_reg_id] <= 1'b0;
      end
      if (clear_up) begin
        busy <= '0;
      end else if (issue_fire) begin
        busy[issue_reg_id] <= 1'b1;
        tags[issue_reg_id] <= issue_rob_entry;
      end
    end
  end

endmodule
